// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Two-port arbiter in front of an SDRAM controller. Port 0 (CPU) issues
//   reads and byte-masked writes. Port 1 (video fetch) issues reads only.
//   Port 1 normally wins, but it can take at most STARVE_MAX consecutive
//   grants while port 0 is waiting.
//
// Ports
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   p0_req/we/addr/din/be         port 0 request, write flag, byte address, data, byte enables
//   p0_ack/p0_dout                port 0 completion pulse and read data
//   p1_req/p1_addr                port 1 read request and byte address
//   p1_ack/p1_dout                port 1 completion pulse and read data
//   sd_raddr/sd_rd                controller read address and read strobe
//   sd_rd_rdy/sd_dout             controller read-ready level and read data
//   sd_waddr/sd_din/sd_be/sd_we   controller write address, data, byte enables, write strobe
//   sd_we_rdy                     controller write-ready level
//   busy/gnt                      FSM not in IDLE / port owning the controller
module sdram_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [24:0] p0_addr,
    input  logic [31:0] p0_din,
    input  logic [3:0]  p0_be,
    output logic        p0_ack,
    output logic [31:0] p0_dout,
    input  logic        p1_req,
    input  logic [24:0] p1_addr,
    output logic        p1_ack,
    output logic [31:0] p1_dout,
    output logic [24:0] sd_raddr,
    output logic        sd_rd,
    input  logic        sd_rd_rdy,
    input  logic [31:0] sd_dout,
    output logic [24:0] sd_waddr,
    output logic [31:0] sd_din,
    output logic [3:0]  sd_be,
    output logic        sd_we,
    input  logic        sd_we_rdy,
    output logic        busy,
    output logic        gnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ACK} state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        we_q, we_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        busy_q, busy_d;
    logic        p0_ack_q, p0_ack_d;
    logic        p1_ack_q, p1_ack_d;
    logic [1:0]  starve_q, starve_d;
    logic [24:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] p0_dout_q, p0_dout_d;
    logic [31:0] p1_dout_q, p1_dout_d;
    logic        rdy_sel;
    logic        p1_wins;

    always_comb begin
        // Ready line belonging to the transfer in flight.
        rdy_sel   = we_q ? sd_we_rdy : sd_rd_rdy;
        p1_wins   = p1_req && (!p0_req || (int'(starve_q) < STARVE_MAX));

        state_d   = state_q;
        gnt_d     = gnt_q;
        we_d      = we_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        starve_d  = starve_q;
        addr_d    = addr_q;
        din_d     = din_q;
        be_d      = be_q;
        p0_dout_d = p0_dout_q;
        p1_dout_d = p1_dout_q;
        p0_ack_d  = 1'b0;
        p1_ack_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!p0_req) starve_d = 2'd0;
                // Only arbitrate when the controller can take either kind of access.
                if (sd_rd_rdy && sd_we_rdy) begin
                    if (p1_wins) begin
                        gnt_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = p1_addr;
                        din_d   = 32'd0;
                        be_d    = 4'd0;
                        rd_d    = 1'b1;
                        state_d = ISSUE;
                        if (p0_req && starve_q != 2'b11) starve_d = starve_q + 2'd1;
                    end else if (p0_req) begin
                        gnt_d    = 1'b0;
                        we_d     = p0_we;
                        addr_d   = p0_addr;
                        din_d    = p0_din;
                        be_d     = p0_we ? p0_be : 4'd0;
                        rd_d     = !p0_we;
                        wr_d     = p0_we;
                        starve_d = 2'd0;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Controller dropping its ready level means it has taken the command.
                if (!rdy_sel) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (rdy_sel) begin
                    if (!we_q) begin
                        if (gnt_q) p1_dout_d = sd_dout;
                        else       p0_dout_d = sd_dout;
                    end
                    if (gnt_q) p1_ack_d = 1'b1;
                    else       p0_ack_d = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            we_q      <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            p0_ack_q  <= 1'b0;
            p1_ack_q  <= 1'b0;
            starve_q  <= 2'd0;
            addr_q    <= 25'd0;
            din_q     <= 32'd0;
            be_q      <= 4'd0;
            p0_dout_q <= 32'd0;
            p1_dout_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            busy_q    <= busy_d;
            p0_ack_q  <= p0_ack_d;
            p1_ack_q  <= p1_ack_d;
            starve_q  <= starve_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            be_q      <= be_d;
            p0_dout_q <= p0_dout_d;
            p1_dout_q <= p1_dout_d;
        end
    end

    assign p0_ack   = p0_ack_q;
    assign p0_dout  = p0_dout_q;
    assign p1_ack   = p1_ack_q;
    assign p1_dout  = p1_dout_q;
    assign sd_raddr = addr_q;
    assign sd_waddr = addr_q;
    assign sd_din   = din_q;
    assign sd_be    = be_q;
    assign sd_rd    = rd_q;
    assign sd_we    = wr_q;
    assign busy     = busy_q;
    assign gnt      = gnt_q;

endmodule
